// File: rtl/serial_mag_comparator.sv
// rtl/serial_mag_comparator.sv - digit-serial MSB-first magnitude comparator with start/busy/done handshake
// Signed operands are mapped to offset binary at capture so the serial datapath is always unsigned.
module serial_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_mag_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  logic [SW-1:0]    step;
  logic             decided, dec_gt;
  logic             gt_r, eq_r, lt_r, done_r;
  logic [DIGIT-1:0] top_a, top_b;
  logic             differ, last, accept, fin_gt, fin_lt;
  logic [WIDTH-1:0] msb_flip;

  always_comb begin
    top_a    = sa[WIDTH-1 -: DIGIT];
    top_b    = sb[WIDTH-1 -: DIGIT];
    differ   = (top_a != top_b);
    last     = (step == SW'(NSTEP - 1)) || ((EARLY_EXIT != 0) && !decided && differ);
    // An earlier latched decision always beats the digit currently on top.
    fin_gt   = decided ? dec_gt  : (differ && (top_a > top_b));
    fin_lt   = decided ? !dec_gt : (differ && (top_a < top_b));
    accept   = en && start && (state == IDLE);
    msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};
    state_nx = state;
    case (state)
      IDLE:    if (accept)     state_nx = RUN;
      RUN:     if (en && last) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa      <= '0;
      sb      <= '0;
      step    <= '0;
      decided <= 1'b0;
      dec_gt  <= 1'b0;
      gt_r    <= 1'b0;
      eq_r    <= 1'b0;
      lt_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      // A done raised while en is low stays pending until it can be seen.
      if (en) done_r <= 1'b0;
      if (accept) begin
        sa      <= a ^ msb_flip;
        sb      <= b ^ msb_flip;
        step    <= '0;
        decided <= 1'b0;
        dec_gt  <= 1'b0;
      end else if (en && state == RUN) begin
        sa   <= sa << DIGIT;
        sb   <= sb << DIGIT;
        step <= step + 1'b1;
        if (!decided && differ) begin
          decided <= 1'b1;
          dec_gt  <= (top_a > top_b);
        end
        if (last) begin
          gt_r   <= fin_gt;
          lt_r   <= fin_lt;
          eq_r   <= !(fin_gt || fin_lt);
          done_r <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = done_r & en;
  assign gt   = gt_r & en;
  assign eq   = eq_r & en;
  assign lt   = lt_r & en;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb/tb_serial_mag_comparator.sv - scoreboard bench for serial_mag_comparator
// dut0 runs every digit, dut1 exits on the first differing digit.
module tb_serial_mag_comparator;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  typedef struct {
    logic [2:0] flags;
    int         when;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, en0, en1, start0, start1, sm;
  logic [7:0] a, b;
  logic       busy0, done0, gt0, eq0, lt0;
  logic       busy1, done1, gt1, eq1, lt1;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  exp_t       q0[$];
  exp_t       q1[$];

  serial_mag_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .start(start0), .a(a), .b(b),
    .signed_mode(sm), .busy(busy0), .done(done0), .gt(gt0), .eq(eq0), .lt(lt0)
  );

  serial_mag_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .start(start1), .a(a), .b(b),
    .signed_mode(sm), .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue a start on one unit and book its expected flags and done cycle.
  task automatic go(input int u, input logic [7:0] av, input logic [7:0] bv,
                    input logic s, input logic [2:0] flags, input int lat);
    exp_t e;
    a = av;
    b = bv;
    sm = s;
    e.flags = flags;
    e.when = cyc + 1 + lat;
    if (u == 0) begin
      start0 = 1'b1;
      q0.push_back(e);
    end else begin
      start1 = 1'b1;
      q1.push_back(e);
    end
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    chk(u == 0 ? "busy0 after start" : "busy1 after start", u == 0 ? busy0 : busy1, 1);
  endtask

  task automatic wait_q(input int u);
    int n;
    for (int i = 0; i < 100; i++) begin
      n = (u == 0) ? q0.size() : q1.size();
      if (n == 0) break;
      tick();
    end
    n = (u == 0) ? q0.size() : q1.size();
    if (n != 0) begin
      chk("done timeout", 0, 1);
      if (u == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) chk("dut0 unexpected done", 1, 0);
      else begin
        e = q0.pop_front();
        chk("dut0 flags", {gt0, eq0, lt0}, e.flags);
        chk("dut0 done cycle", cyc, e.when);
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("dut1 unexpected done", 1, 0);
      else begin
        e = q1.pop_front();
        chk("dut1 flags", {gt1, eq1, lt1}, e.flags);
        chk("dut1 done cycle", cyc, e.when);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en0 = 1'b1; en1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    sm = 1'b0; a = '0; b = '0;
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("reset dut0 outputs", {busy0, done0, gt0, eq0, lt0}, 0);
    chk("reset dut1 outputs", {busy1, done1, gt1, eq1, lt1}, 0);
    rst_n = 1'b1;
    tick();

    // dut0: fixed-latency unit
    go(0, 8'h35, 8'h33, 1'b0, GT, 4);
    wait_q(0);
    chk("dut0 flags held", {gt0, eq0, lt0}, GT);
    chk("dut0 done one cycle", done0, 0);
    chk("dut0 idle", busy0, 0);
    go(0, 8'h80, 8'h7F, 1'b1, LT, 4);
    wait_q(0);
    go(0, 8'h80, 8'h7F, 1'b0, GT, 4);
    wait_q(0);

    go(0, 8'h12, 8'h34, 1'b0, LT, 4);
    a = 8'h99; b = 8'h00; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_q(0);

    go(0, 8'h35, 8'h33, 1'b0, GT, 7);
    tick();
    en0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dut0 flags masked", {gt0, eq0, lt0}, 0);
    end
    en0 = 1'b1;
    wait_q(0);

    go(0, 8'h00, 8'h01, 1'b0, LT, 6);
    repeat (4) tick();
    en0 = 1'b0;
    tick();
    chk("dut0 pending done masked", {done0, gt0, eq0, lt0}, 0);
    tick();
    en0 = 1'b1;
    wait_q(0);

    a = 8'h35; b = 8'h33; sm = 1'b0; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort busy", busy0, 0);
    chk("abort flags", {gt0, eq0, lt0}, 0);
    repeat (8) tick();
    chk("abort no done", busy0, 0);

    // dut1: early-exit unit
    go(1, 8'hA5, 8'hA5, 1'b0, EQ, 4);
    repeat (4) tick();
    go(1, 8'hA5, 8'hA5, 1'b1, EQ, 4);
    wait_q(1);
    go(1, 8'hC0, 8'h00, 1'b0, GT, 1);
    wait_q(1);
    go(1, 8'h0C, 8'h0D, 1'b0, LT, 4);
    wait_q(1);
    go(1, 8'h35, 8'h33, 1'b0, GT, 3);
    wait_q(1);
    go(1, 8'h80, 8'h7F, 1'b1, LT, 1);
    wait_q(1);
    chk("dut1 flags held", {gt1, eq1, lt1}, LT);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
